// File: rtl/register_read_stage.sv
// Register read stage: fetches four source operands for an instruction pair
// from the register-set outputs, forwards same-cycle writebacks, stalls on
// RAW/WAW hazards against pending writebacks (busy-bit scoreboard), and
// presents operands through a 1-deep valid/ready output register.
module register_read_stage #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     srcA1,
  input  logic [AW-1:0]     srcA2,
  input  logic [AW-1:0]     srcB1,
  input  logic [AW-1:0]     srcB2,
  input  logic [AW-1:0]     destA,
  input  logic [AW-1:0]     destB,
  input  logic              destA_en,
  input  logic              destB_en,
  input  logic [DATA_W-1:0] outR0,
  input  logic [DATA_W-1:0] outR1,
  input  logic [DATA_W-1:0] outR2,
  input  logic [DATA_W-1:0] outR3,
  input  logic [DATA_W-1:0] outR4,
  input  logic [DATA_W-1:0] outR5,
  input  logic [DATA_W-1:0] outR6,
  input  logic [DATA_W-1:0] outR7,
  input  logic              regWrite1,
  input  logic              regWrite2,
  input  logic [AW-1:0]     wrAddr1,
  input  logic [AW-1:0]     wrAddr2,
  input  logic [DATA_W-1:0] writeData1,
  input  logic [DATA_W-1:0] writeData2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] opA1,
  output logic [DATA_W-1:0] opA2,
  output logic [DATA_W-1:0] opB1,
  output logic [DATA_W-1:0] opB2,
  output logic [AW-1:0]     out_destA,
  output logic [AW-1:0]     out_destB,
  output logic              pair_conflict,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Register-set view and source address list (A1, A2, B1, B2).
  logic [DATA_W-1:0] reg_set  [NREG];
  logic [AW-1:0]     src_addr [4];
  logic [DATA_W-1:0] fetched  [4];
  logic [3:0]        src_hazard;

  assign reg_set[0] = outR0;
  assign reg_set[1] = outR1;
  assign reg_set[2] = outR2;
  assign reg_set[3] = outR3;
  assign reg_set[4] = outR4;
  assign reg_set[5] = outR5;
  assign reg_set[6] = outR6;
  assign reg_set[7] = outR7;

  assign src_addr[0] = srcA1;
  assign src_addr[1] = srcA2;
  assign src_addr[2] = srcB1;
  assign src_addr[3] = srcB2;

  // State registers.
  logic              out_valid_q;
  logic [DATA_W-1:0] opA1_q, opA2_q, opB1_q, opB2_q;
  logic [AW-1:0]     destA_q, destB_q;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              conflict_q;
  logic [CNT_W-1:0]  stall_q, stall_d;

  // A register whose pending writeback lands this cycle.
  logic [NREG-1:0] cleared;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_clear
      assign cleared[gi] = (regWrite1 && (wrAddr1 == AW'(gi))) ||
                           (regWrite2 && (wrAddr2 == AW'(gi)));
    end
  endgenerate

  // Operand fetch with writeback forwarding; port 2 overrides port 1, R0 is zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fetched[i] = reg_set[src_addr[i]];
      if (regWrite1 && (wrAddr1 == src_addr[i])) fetched[i] = writeData1;
      if (regWrite2 && (wrAddr2 == src_addr[i])) fetched[i] = writeData2;
      if (src_addr[i] == '0) fetched[i] = '0;
      src_hazard[i] = (src_addr[i] != '0) && busy_q[src_addr[i]] && !cleared[src_addr[i]];
    end
  end

  logic waw_a, waw_b, hazard, accept, pair_dep;

  assign waw_a  = destA_en && (destA != '0) && busy_q[destA] && !cleared[destA];
  assign waw_b  = destB_en && (destB != '0) && busy_q[destB] && !cleared[destB];
  assign hazard = (|src_hazard) || waw_a || waw_b;

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // B depends on A's result (or both write the same register) within one pair.
  assign pair_dep = destA_en && (destA != '0) &&
                    ((srcB1 == destA) || (srcB2 == destA) || (destB_en && (destB == destA)));

  // Busy bits: an accepted destination sets, a writeback clears, set wins.
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_r0
        assign busy_d[gi] = 1'b0;
      end else begin : g_rn
        assign busy_d[gi] = (accept && ((destA_en && (destA == AW'(gi))) ||
                                        (destB_en && (destB == AW'(gi))))) ? 1'b1 :
                            cleared[gi] ? 1'b0 : busy_q[gi];
      end
    end
  endgenerate

  assign stall_d = (in_valid && hazard && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;

  // Output register, scoreboard, sticky conflict flag and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      opA1_q      <= '0;
      opA2_q      <= '0;
      opB1_q      <= '0;
      opB2_q      <= '0;
      destA_q     <= '0;
      destB_q     <= '0;
      busy_q      <= '0;
      conflict_q  <= 1'b0;
      stall_q     <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        opA1_q      <= fetched[0];
        opA2_q      <= fetched[1];
        opB1_q      <= fetched[2];
        opB2_q      <= fetched[3];
        destA_q     <= destA;
        destB_q     <= destB;
        if (pair_dep) conflict_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign opA1          = opA1_q;
  assign opA2          = opA2_q;
  assign opB1          = opB1_q;
  assign opB2          = opB2_q;
  assign out_destA     = destA_q;
  assign out_destB     = destB_q;
  assign pair_conflict = conflict_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_register_read_stage.sv
// Testbench for register_read_stage: scenario tasks with inline checks plus a
// scoreboard of expected operand sets, popped when the execute side consumes.
module tb_register_read_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  srcA1, srcA2, srcB1, srcB2, destA, destB;
  logic        destA_en, destB_en;
  logic [31:0] mdl_reg [8];
  logic        regWrite1, regWrite2;
  logic [2:0]  wrAddr1, wrAddr2;
  logic [31:0] writeData1, writeData2;
  logic        out_valid, out_ready;
  logic [31:0] opA1, opA2, opB1, opB2;
  logic [2:0]  out_destA, out_destB;
  logic        pair_conflict;
  logic [15:0] stall_cnt;

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    logic [31:0] a1, a2, b1, b2;
    logic [2:0]  da, db;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  register_read_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .srcA1(srcA1), .srcA2(srcA2), .srcB1(srcB1), .srcB2(srcB2),
    .destA(destA), .destB(destB), .destA_en(destA_en), .destB_en(destB_en),
    .outR0(mdl_reg[0]), .outR1(mdl_reg[1]), .outR2(mdl_reg[2]), .outR3(mdl_reg[3]),
    .outR4(mdl_reg[4]), .outR5(mdl_reg[5]), .outR6(mdl_reg[6]), .outR7(mdl_reg[7]),
    .regWrite1(regWrite1), .regWrite2(regWrite2),
    .wrAddr1(wrAddr1), .wrAddr2(wrAddr2),
    .writeData1(writeData1), .writeData2(writeData2),
    .out_valid(out_valid), .out_ready(out_ready),
    .opA1(opA1), .opA2(opA2), .opB1(opB1), .opB2(opB2),
    .out_destA(out_destA), .out_destB(out_destB),
    .pair_conflict(pair_conflict), .stall_cnt(stall_cnt)
  );

  // Expected operand value under the forwarding rules.
  function automatic logic [31:0] exp_fetch(input logic [2:0] s);
    if (s == 3'd0) return 32'h0;
    if (regWrite2 && wrAddr2 == s) return writeData2;
    if (regWrite1 && wrAddr1 == s) return writeData1;
    return mdl_reg[s];
  endfunction

  // One clock: check consumed output, record accepted input, then apply the
  // register-set write after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: got output %h with no expected entry", opA1);
      end else begin
        e = sb_q.pop_front();
        $display("[TB] xfer opA1=%h opA2=%h opB1=%h opB2=%h dA=%0d dB=%0d", opA1, opA2, opB1, opB2, out_destA, out_destB);
        if ({opA1, opA2, opB1, opB2, out_destA, out_destB} !== {e.a1, e.a2, e.b1, e.b2, e.da, e.db}) begin
          fails++;
          $display("FAIL sb_operands: got %h %h %h %h d%0d d%0d, want %h %h %h %h d%0d d%0d",
                   opA1, opA2, opB1, opB2, out_destA, out_destB, e.a1, e.a2, e.b1, e.b2, e.da, e.db);
        end
      end
    end
    if (in_valid && in_ready) begin
      e.a1 = exp_fetch(srcA1); e.a2 = exp_fetch(srcA2);
      e.b1 = exp_fetch(srcB1); e.b2 = exp_fetch(srcB2);
      e.da = destA; e.db = destB;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (regWrite1 && wrAddr1 != 3'd0) mdl_reg[wrAddr1] = writeData1;
    if (regWrite2 && wrAddr2 != 3'd0) mdl_reg[wrAddr2] = writeData2;
  endtask

  task automatic set_srcs(input logic [2:0] a1, a2, b1, b2);
    srcA1 = a1; srcA2 = a2; srcB1 = b1; srcB2 = b2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 0; set_srcs(0, 0, 0, 0); destA = 0; destB = 0; destA_en = 0; destB_en = 0;
    regWrite1 = 0; regWrite2 = 0; wrAddr1 = 0; wrAddr2 = 0; writeData1 = 0; writeData2 = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) mdl_reg[i] = 32'h0;
    #2;
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if ({opA1, opA2, opB1, opB2} !== 128'h0) begin fails++; $display("FAIL reset_ops: got %h %h %h %h want 0", opA1, opA2, opB1, opB2); end
    tests_run++; if ({out_destA, out_destB} !== 6'h0) begin fails++; $display("FAIL reset_dests: got %0d %0d want 0", out_destA, out_destB); end
    tests_run++; if (pair_conflict !== 1'b0) begin fails++; $display("FAIL reset_conflict: got %b want 0", pair_conflict); end
    tests_run++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fetch();
    mdl_reg[3] = 32'h11; mdl_reg[5] = 32'h22;
    set_srcs(3, 5, 0, 3); in_valid = 1; #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fetch_in_ready: got %b want 1", in_ready); end
    cycle();
    in_valid = 0; #1;
    tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fetch_valid: got %b want 1", out_valid); end
    tests_run++;
    if ({opA1, opA2, opB1, opB2} !== {32'h11, 32'h22, 32'h0, 32'h11}) begin
      fails++; $display("FAIL fetch_ops: got %h %h %h %h want 11 22 0 11", opA1, opA2, opB1, opB2);
    end
    cycle();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fetch_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_raw_stall();
    set_srcs(0, 0, 0, 0); destA = 4; destA_en = 1; in_valid = 1;
    cycle();
    destA_en = 0; srcA1 = 4; #1;
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_in_ready: got %b want 0", in_ready); end
    for (int i = 1; i <= 3; i++) begin
      cycle();
      tests_run++; if (stall_cnt !== 16'(i)) begin fails++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, i); end
    end
    regWrite1 = 1; wrAddr1 = 4; writeData1 = 32'hABCD; #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL raw_wb_in_ready: got %b want 1", in_ready); end
    cycle();
    regWrite1 = 0; in_valid = 0; #1;
    tests_run++; if (opA1 !== 32'hABCD) begin fails++; $display("FAIL raw_fwd_opA1: got %h want abcd", opA1); end
    tests_run++; if (stall_cnt !== 16'd3) begin fails++; $display("FAIL raw_stall_hold: got %0d want 3", stall_cnt); end
    in_valid = 1; #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL raw_busy_cleared: got %b want 1", in_ready); end
    cycle();
    in_valid = 0;
    cycle();
  endtask

  task automatic test_forward_prio();
    regWrite1 = 1; wrAddr1 = 6; writeData1 = 32'h1;
    regWrite2 = 1; wrAddr2 = 6; writeData2 = 32'h2;
    set_srcs(6, 0, 0, 0); in_valid = 1;
    cycle();
    regWrite1 = 0; regWrite2 = 0; in_valid = 0; #1;
    tests_run++; if (opA1 !== 32'h2) begin fails++; $display("FAIL prio_opA1: got %h want 2", opA1); end
    cycle();
  endtask

  task automatic test_back_to_back();
    mdl_reg[1] = 32'h1111_0001; mdl_reg[2] = 32'h2222_0002;
    set_srcs(1, 2, 2, 1); destA = 5; destB = 6; destA_en = 0; destB_en = 0;
    out_ready = 0; in_valid = 1;
    cycle();
    set_srcs(5, 3, 6, 7); destA = 1; destB = 2;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
      tests_run++;
      if ({out_valid, opA1, opB1, out_destA} !== {1'b1, 32'h1111_0001, 32'h2222_0002, 3'd5}) begin
        fails++; $display("FAIL hold_stable: got v=%b %h %h d%0d want 1 11110001 22220002 d5", out_valid, opA1, opB1, out_destA);
      end
      cycle();
    end
    tests_run++; if (stall_cnt !== 16'd3) begin fails++; $display("FAIL hold_no_stall_count: got %0d want 3", stall_cnt); end
    out_ready = 1; #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    cycle();
    in_valid = 0; #1;
    tests_run++;
    if ({out_valid, opA1} !== {1'b1, 32'h22}) begin
      fails++; $display("FAIL b2b_second: got v=%b opA1=%h want 1 22", out_valid, opA1);
    end
    cycle();
  endtask

  task automatic test_pair_conflict();
    #1;
    tests_run++; if (pair_conflict !== 1'b0) begin fails++; $display("FAIL conflict_pre: got %b want 0", pair_conflict); end
    set_srcs(0, 0, 2, 0); destA = 2; destA_en = 1; destB = 0; destB_en = 0; in_valid = 1;
    cycle();
    destA_en = 0; in_valid = 0; #1;
    tests_run++; if (pair_conflict !== 1'b1) begin fails++; $display("FAIL conflict_set: got %b want 1", pair_conflict); end
    regWrite1 = 1; wrAddr1 = 2; writeData1 = 32'h5;
    cycle();
    regWrite1 = 0;
    set_srcs(0, 0, 0, 0); destA = 0; destA_en = 1; in_valid = 1; #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL r0_dest_in_ready: got %b want 1", in_ready); end
    cycle();
    destA_en = 0; #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL r0_no_stall: got %b want 1", in_ready); end
    cycle();
    in_valid = 0;
    cycle();
    tests_run++; if (pair_conflict !== 1'b1) begin fails++; $display("FAIL conflict_sticky: got %b want 1", pair_conflict); end
  endtask

  task automatic test_reset_mid();
    set_srcs(0, 0, 0, 0); destA = 4; destA_en = 1; out_ready = 0; in_valid = 1;
    cycle();
    destA_en = 0; srcA1 = 4;
    cycle();
    cycle();
    tests_run++; if (stall_cnt !== 16'd5) begin fails++; $display("FAIL mid_stall_cnt: got %0d want 5", stall_cnt); end
    tests_run++; if ({out_valid, in_ready} !== 2'b10) begin fails++; $display("FAIL mid_state: got v=%b r=%b want 1 0", out_valid, in_ready); end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, stall_cnt, pair_conflict, opA1} !== {1'b0, 16'd0, 1'b0, 32'h0}) begin
      fails++; $display("FAIL mid_reset: got v=%b cnt=%0d pc=%b opA1=%h want 0 0 0 0", out_valid, stall_cnt, pair_conflict, opA1);
    end
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b0; out_ready = 1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_busy_cleared: got %b want 1", in_ready); end
    cycle();
    in_valid = 0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_raw_stall();
    test_forward_prio();
    test_back_to_back();
    test_pair_conflict();
    test_reset_mid();
    tests_run++;
    if (sb_q.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
